micro_sequencer: RTL

Parametrised, programmable datapath sequencer. It steps through a loadable micro-program and drives the register-file write-enable vector, the A/B read selects and the ALU opcode for each step. It sits between the top level and the regfile/ALU datapath and replaces hard-wired fixed-sequence control FSMs. It adds a start/busy/done handshake, a stall input, early halt and a programmable program length.

---
 rtl/micro_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer -- programmable datapath sequencer.
//
// Steps through a loadable micro-program and, for each entry, drives the
// register-file write enables, the ALU operand selects and the ALU opcode.
// Each entry takes one FETCH cycle and one EXEC cycle.
//
// Entry format (MSB..LSB): {halt, wr, dest, srcA, srcB, op}
//
// Ports:
//   clock, Reset      rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse, starts a run at entry 0 (IDLE only)
//   stall             holds the sequencer in FETCH while high
//   last_addr         index of the final entry, sampled at start
//   prog_we/addr/data program memory write port (accepted in IDLE only)
//   repeat_cnt        extra passes over the program (SEQ_LOOP_EN builds only)
//   busy, done        run in progress / one-cycle completion pulse
//   pc                current program counter
//   regControl        one-hot register write enable (nonzero only in EXEC)
//   regACont/regBCont ALU operand register selects
//   AluOp             ALU operation
//
// Build option: define SEQ_LOOP_EN to add repeat_cnt and looped runs.

module micro_sequencer #(
   parameter int NUM_REGS   = 16,
   parameter int ALUOP_W    = 8,
   parameter int PROG_DEPTH = 16,
   localparam int SEL_W     = $clog2(NUM_REGS),
   localparam int PC_W      = $clog2(PROG_DEPTH),
   localparam int INSTR_W   = 2 + 3*SEL_W + ALUOP_W
) (
   input  logic               clock,
   input  logic               Reset,
   input  logic               start,
   input  logic               stall,
   input  logic [PC_W-1:0]    last_addr,
`ifdef SEQ_LOOP_EN
   input  logic [7:0]         repeat_cnt,
`endif
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic               busy,
   output logic               done,
   output logic [PC_W-1:0]    pc,
   output logic [NUM_REGS-1:0] regControl,
   output logic [SEL_W-1:0]   regACont,
   output logic [SEL_W-1:0]   regBCont,
   output logic [ALUOP_W-1:0] AluOp
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [PC_W-1:0]      last_q, last_d;
   logic                 halt_q, halt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [NUM_REGS-1:0]  regctl_q, regctl_d;
   logic [SEL_W-1:0]     rega_q, rega_d;
   logic [SEL_W-1:0]     regb_q, regb_d;
   logic [ALUOP_W-1:0]   op_q, op_d;
`ifdef SEQ_LOOP_EN
   logic [7:0]           rep_q, rep_d;
`endif

   // Program memory: no reset, contents survive Reset.
   logic [INSTR_W-1:0]   mem [PROG_DEPTH];

   always_ff @(posedge clock) begin
      if (prog_we && state_q == IDLE)
         mem[prog_addr] <= prog_data;
   end

   logic [INSTR_W-1:0]   f_word;
   logic                 f_halt, f_wr;
   logic [SEL_W-1:0]     f_dest, f_srca, f_srcb;
   logic [ALUOP_W-1:0]   f_op;

   always_comb begin
      f_word = mem[pc_q];
      f_halt = f_word[INSTR_W-1];
      f_wr   = f_word[INSTR_W-2];
      f_dest = f_word[INSTR_W-3 -: SEL_W];
      f_srca = f_word[INSTR_W-3-SEL_W -: SEL_W];
      f_srcb = f_word[ALUOP_W+SEL_W-1 -: SEL_W];
      f_op   = f_word[ALUOP_W-1:0];
   end

   // Outputs are registered, so the EXEC drive values are decoded on the
   // FETCH->EXEC transition from the entry being fetched.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      last_d   = last_q;
      halt_d   = halt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      regctl_d = '0;
      rega_d   = '0;
      regb_d   = '0;
      op_d     = '0;
`ifdef SEQ_LOOP_EN
      rep_d    = rep_q;
`endif
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               state_d = FETCH;
               pc_d    = '0;
               last_d  = last_addr;
               busy_d  = 1'b1;
`ifdef SEQ_LOOP_EN
               rep_d   = repeat_cnt;
`endif
            end
         end
         FETCH: begin
            if (!stall) begin
               state_d = EXEC;
               halt_d  = f_halt;
               for (int unsigned i = 0; i < NUM_REGS; i++)
                  regctl_d[i] = f_wr && (f_dest == SEL_W'(i));
               rega_d  = f_srca;
               regb_d  = f_srcb;
               op_d    = f_op;
            end
         end
         EXEC: begin
            if (halt_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (pc_q == last_q) begin
`ifdef SEQ_LOOP_EN
               if (rep_q != 8'd0) begin
                  rep_d   = rep_q - 8'd1;
                  pc_d    = '0;
                  state_d = FETCH;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
`else
               state_d = DONE;
               done_d  = 1'b1;
`endif
            end else begin
               pc_d    = pc_q + PC_W'(1);
               state_d = FETCH;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         last_q   <= '0;
         halt_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         regctl_q <= '0;
         rega_q   <= '0;
         regb_q   <= '0;
         op_q     <= '0;
`ifdef SEQ_LOOP_EN
         rep_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         last_q   <= last_d;
         halt_q   <= halt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         regctl_q <= regctl_d;
         rega_q   <= rega_d;
         regb_q   <= regb_d;
         op_q     <= op_d;
`ifdef SEQ_LOOP_EN
         rep_q    <= rep_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign pc         = pc_q;
   assign regControl = regctl_q;
   assign regACont   = rega_q;
   assign regBCont   = regb_q;
   assign AluOp      = op_q;

endmodule
